// File: rtl/sensor_poll_sched.sv
// Tick-driven round scheduler: RH/temp trigger, then light/IMU/mag, then RH/temp read.
// Define SENSOR_ATOMIC_UPDATE_EN to stage words in shadows and publish at FINISH.
module sensor_poll_sched #(
    parameter int PERIOD  = 500000,
    parameter int TIMEOUT = 65535
) (
    input  logic        CLK_50,
    input  logic        RESET_n,
    input  logic        EN,
    input  logic        RH_TEMP_DRDY_n,
    output logic        HM_TR,
    output logic        REQ,
    output logic [1:0]  REQ_ID,
    input  logic        ACK,
    input  logic        RD_VALID,
    input  logic [15:0] RD_DATA,
    input  logic        DONE,
    input  logic        ERR,
    output logic [7:0]  Temperature,
    output logic [7:0]  HUMITY,
    output logic [15:0] Ambient_LIGHT0,
    output logic [15:0] Ambient_LIGHT1,
    output logic [15:0] ACCELEROMETER_X,
    output logic [15:0] ACCELEROMETER_Y,
    output logic [15:0] ACCELEROMETER_Z,
    output logic [15:0] GYROSCOPE_X,
    output logic [15:0] GYROSCOPE_Y,
    output logic [15:0] GYROSCOPE_Z,
    output logic [15:0] MAGNETOMETER_X,
    output logic [15:0] MAGNETOMETER_Y,
    output logic [15:0] MAGNETOMETER_Z,
    output logic        UPDATE,
    output logic [7:0]  ERR_CNT
);

    localparam int CW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, TRIG, ISSUE, COLLECT, NEXT, WAIT_DRDY, FINISH
    } state_t;

    function automatic logic [2:0] wcnt(input logic [1:0] s);
        unique case (s)
            2'd0: wcnt = 3'd1;
            2'd1: wcnt = 3'd2;
            2'd2: wcnt = 3'd6;
            default: wcnt = 3'd3;
        endcase
    endfunction

    // Word storage: 0 RH/temp, 1-2 light, 3-8 accel/gyro, 9-11 mag
    function automatic logic [3:0] wbase(input logic [1:0] s);
        unique case (s)
            2'd0: wbase = 4'd0;
            2'd1: wbase = 4'd1;
            2'd2: wbase = 4'd3;
            default: wbase = 4'd9;
        endcase
    endfunction

    state_t          state_q;
    logic [CW-1:0]   tick_q;
    logic            pend_q;
    logic [TW-1:0]   timer_q;
    logic [1:0]      slot_q;
    logic [2:0]      idx_q;
    logic            hm_tr_q;
    logic            req_q;
    logic [1:0]      req_id_q;
    logic            upd_q;
    logic [7:0]      err_q;
    logic [15:0]     d_q [12];

`ifdef SENSOR_ATOMIC_UPDATE_EN
    logic [15:0]     sh_q [12];
    logic [3:0]      shv_q;

    function automatic logic [1:0] wslot(input logic [3:0] i);
        if (i == 4'd0)      wslot = 2'd0;
        else if (i < 4'd3)  wslot = 2'd1;
        else if (i < 4'd9)  wslot = 2'd2;
        else                wslot = 2'd3;
    endfunction
`endif

    logic        in_coll;
    logic        take;
    logic [2:0]  nwords;
    logic        tmo;
    logic [3:0]  wptr;
    logic [7:0]  err_inc;

    assign in_coll = (state_q == COLLECT) ||
                     (state_q == ISSUE && req_q && ACK);
    assign take    = in_coll && RD_VALID && (idx_q < wcnt(slot_q));
    assign nwords  = idx_q + {2'd0, take};
    assign tmo     = (timer_q == TW'(TIMEOUT - 1));
    assign wptr    = wbase(slot_q) + {1'b0, idx_q};
    assign err_inc = err_q + {7'd0, err_q != 8'hFF};

    always_ff @(posedge CLK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= IDLE;
            tick_q   <= CW'(PERIOD - 1);
            pend_q   <= 1'b0;
            timer_q  <= '0;
            slot_q   <= '0;
            idx_q    <= '0;
            hm_tr_q  <= 1'b0;
            req_q    <= 1'b0;
            req_id_q <= '0;
            upd_q    <= 1'b0;
            err_q    <= '0;
            for (int i = 0; i < 12; i++) d_q[i] <= '0;
`ifdef SENSOR_ATOMIC_UPDATE_EN
            for (int i = 0; i < 12; i++) sh_q[i] <= '0;
            shv_q    <= '0;
`endif
        end else begin
            hm_tr_q <= 1'b0;
            upd_q   <= 1'b0;
            timer_q <= timer_q + TW'(1);
            unique case (state_q)
                IDLE: begin
                    if (pend_q && EN) begin
                        pend_q  <= 1'b0;
                        hm_tr_q <= 1'b1;
                        state_q <= TRIG;
                    end
                end
                TRIG: begin
                    slot_q  <= 2'd1;
                    idx_q   <= '0;
                    timer_q <= '0;
                    state_q <= ISSUE;
`ifdef SENSOR_ATOMIC_UPDATE_EN
                    shv_q   <= '0;
`endif
                end
                ISSUE: begin
                    if (req_q && ACK) begin
                        req_q   <= 1'b0;
                        timer_q <= '0;
                        state_q <= COLLECT;
                    end else if (tmo) begin
                        req_q   <= 1'b0;
                        err_q   <= err_inc;
                        state_q <= NEXT;
                    end else begin
                        req_q    <= 1'b1;
                        req_id_q <= slot_q;
                    end
                end
                COLLECT: begin
                    if (tmo && !DONE) begin
                        err_q   <= err_inc;
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    idx_q   <= '0;
                    timer_q <= '0;
                    unique case (slot_q)
                        2'd1: begin slot_q <= 2'd2; state_q <= ISSUE; end
                        2'd2: begin slot_q <= 2'd3; state_q <= ISSUE; end
                        2'd3: state_q <= WAIT_DRDY;
                        default: begin
                            upd_q   <= 1'b1;
                            state_q <= FINISH;
`ifdef SENSOR_ATOMIC_UPDATE_EN
                            for (int i = 0; i < 12; i++)
                                if (shv_q[wslot(4'(i))]) d_q[i] <= sh_q[i];
                            shv_q   <= '0;
`endif
                        end
                    endcase
                end
                WAIT_DRDY: begin
                    if (!RH_TEMP_DRDY_n) begin
                        slot_q  <= 2'd0;
                        idx_q   <= '0;
                        timer_q <= '0;
                        state_q <= ISSUE;
                    end else if (tmo) begin
                        slot_q  <= 2'd0;
                        err_q   <= err_inc;
                        state_q <= NEXT;
                    end
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (take) begin
                idx_q <= idx_q + 3'd1;
`ifdef SENSOR_ATOMIC_UPDATE_EN
                sh_q[wptr] <= RD_DATA;
`else
                d_q[wptr] <= RD_DATA;
`endif
            end
            // DONE also covers the ACK+DONE same-cycle case out of ISSUE
            if (in_coll && DONE) begin
                state_q <= NEXT;
                if (ERR || nwords < wcnt(slot_q)) begin
                    err_q <= err_inc;
`ifdef SENSOR_ATOMIC_UPDATE_EN
                end else begin
                    shv_q[slot_q] <= 1'b1;
`endif
                end
            end
            if (tick_q == '0) begin
                tick_q <= CW'(PERIOD - 1);
                pend_q <= 1'b1;
            end else begin
                tick_q <= tick_q - CW'(1);
            end
        end
    end

    assign HM_TR           = hm_tr_q;
    assign REQ             = req_q;
    assign REQ_ID          = req_id_q;
    assign UPDATE          = upd_q;
    assign ERR_CNT         = err_q;
    assign Temperature     = d_q[0][15:8];
    assign HUMITY          = d_q[0][7:0];
    assign Ambient_LIGHT0  = d_q[1];
    assign Ambient_LIGHT1  = d_q[2];
    assign ACCELEROMETER_X = d_q[3];
    assign ACCELEROMETER_Y = d_q[4];
    assign ACCELEROMETER_Z = d_q[5];
    assign GYROSCOPE_X     = d_q[6];
    assign GYROSCOPE_Y     = d_q[7];
    assign GYROSCOPE_Z     = d_q[8];
    assign MAGNETOMETER_X  = d_q[9];
    assign MAGNETOMETER_Y  = d_q[10];
    assign MAGNETOMETER_Z  = d_q[11];

endmodule

// File: tb/tb_sensor_poll_sched.sv
// Scoreboard bench for sensor_poll_sched: modelled bus engine and RH/temp sensor,
// expected request IDs and round snapshots queued by stimulus, checked by a monitor.
module tb_sensor_poll_sched;

    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        drdy_n = 1'b1;
    logic        ack = 1'b0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data = '0;
    logic        done = 1'b0;
    logic        err = 1'b0;

    logic        HM_TR, REQ, UPDATE;
    logic [1:0]  REQ_ID;
    logic [7:0]  Temperature, HUMITY, ERR_CNT;
    logic [15:0] L0, L1, AX, AY, AZ, GX, GY, GZ, MX, MY, MZ;

    sensor_poll_sched #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .CLK_50(clk), .RESET_n(rst_n), .EN(en),
        .RH_TEMP_DRDY_n(drdy_n), .HM_TR(HM_TR),
        .REQ(REQ), .REQ_ID(REQ_ID), .ACK(ack),
        .RD_VALID(rd_valid), .RD_DATA(rd_data),
        .DONE(done), .ERR(err),
        .Temperature(Temperature), .HUMITY(HUMITY),
        .Ambient_LIGHT0(L0), .Ambient_LIGHT1(L1),
        .ACCELEROMETER_X(AX), .ACCELEROMETER_Y(AY),
        .ACCELEROMETER_Z(AZ), .GYROSCOPE_X(GX),
        .GYROSCOPE_Y(GY), .GYROSCOPE_Z(GZ),
        .MAGNETOMETER_X(MX), .MAGNETOMETER_Y(MY),
        .MAGNETOMETER_Z(MZ), .UPDATE(UPDATE),
        .ERR_CNT(ERR_CNT)
    );

    always #5 clk = ~clk;

    typedef logic [223:0] snap_t;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int hm_cnt = 0;
    int ack_dly = 0;
    int done_dly = 0;
    int err_slot = 7;
    bit drdy_hold = 1'b0;
    int dcnt = 0;

    logic [15:0] w0;
    logic [15:0] w1 [2];
    logic [15:0] w2 [6];
    logic [15:0] w3 [3];
    logic [15:0] m [14];

    logic [1:0] exp_req[$];
    snap_t      exp_upd[$];

    string nm [14] = '{"temperature", "humidity", "light0", "light1",
                       "acc_x", "acc_y", "acc_z", "gyro_x", "gyro_y",
                       "gyro_z", "mag_x", "mag_y", "mag_z", "err_cnt"};

    task automatic chk(input string n, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, want);
        end
    endtask

    function automatic snap_t dut_snap();
        snap_t s;
        s[0*16 +: 16]  = {8'h00, Temperature};
        s[1*16 +: 16]  = {8'h00, HUMITY};
        s[2*16 +: 16]  = L0;
        s[3*16 +: 16]  = L1;
        s[4*16 +: 16]  = AX;
        s[5*16 +: 16]  = AY;
        s[6*16 +: 16]  = AZ;
        s[7*16 +: 16]  = GX;
        s[8*16 +: 16]  = GY;
        s[9*16 +: 16]  = GZ;
        s[10*16 +: 16] = MX;
        s[11*16 +: 16] = MY;
        s[12*16 +: 16] = MZ;
        s[13*16 +: 16] = {8'h00, ERR_CNT};
        return s;
    endfunction

    function automatic logic [15:0] word(input logic [1:0] s, input int i);
        case (s)
            2'd0: return w0;
            2'd1: return w1[i];
            2'd2: return w2[i];
            default: return w3[i];
        endcase
    endfunction

    function automatic int nwords(input logic [1:0] s);
        case (s)
            2'd0: return 1;
            2'd1: return 2;
            2'd2: return 6;
            default: return 3;
        endcase
    endfunction

    // Bus engine model
    initial begin
        logic [1:0] s;
        forever begin
            @(negedge clk);
            if (REQ && rst_n) begin
                s = REQ_ID;
                repeat (ack_dly) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                repeat (done_dly) @(negedge clk);
                if (int'(s) == err_slot) begin
                    done = 1'b1;
                    err = 1'b1;
                    @(negedge clk);
                end else begin
                    for (int i = 0; i < nwords(s); i++) begin
                        rd_valid = 1'b1;
                        rd_data = word(s, i);
                        done = (i == nwords(s) - 1);
                        @(negedge clk);
                    end
                end
                rd_valid = 1'b0;
                done = 1'b0;
                err = 1'b0;
            end
        end
    end

    // RH/temp sensor: ready 20 cycles after each trigger
    initial forever begin
        @(negedge clk);
        if (HM_TR) begin
            drdy_n = 1'b1;
            dcnt = 20;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0 && !drdy_hold) drdy_n = 1'b0;
        end
    end

    // Monitor
    initial forever begin
        snap_t g, e;
        @(negedge clk);
        #1;
        if (rst_n && REQ && ack) begin
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_id: unexpected request %0d", REQ_ID);
            end else begin
                chk("req_id", {14'd0, REQ_ID}, {14'd0, exp_req.pop_front()});
            end
        end
        if (rst_n && UPDATE) begin
            upd_cnt++;
            if (exp_upd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL update: unexpected UPDATE pulse");
            end else begin
                g = dut_snap();
                e = exp_upd.pop_front();
                for (int i = 0; i < 14; i++)
                    chk(nm[i], g[i*16 +: 16], e[i*16 +: 16]);
            end
        end
        if (rst_n && HM_TR) hm_cnt++;
    end

    task automatic cfg(input logic [15:0] b, input logic [15:0] z);
        for (int i = 0; i < 2; i++) w1[i] = b + 16'h0010 + 16'(i);
        for (int i = 0; i < 6; i++) w2[i] = b + 16'h0020 + 16'(i);
        for (int i = 0; i < 3; i++) w3[i] = b + 16'h0030 + 16'(i);
        w0 = z;
    endtask

    task automatic apply(input int s);
        case (s)
            0: begin m[0] = {8'h00, w0[15:8]}; m[1] = {8'h00, w0[7:0]}; end
            1: begin m[2] = w1[0]; m[3] = w1[1]; end
            2: for (int i = 0; i < 6; i++) m[4 + i] = w2[i];
            default: for (int i = 0; i < 3; i++) m[10 + i] = w3[i];
        endcase
    endtask

    task automatic push_snap(input logic [7:0] ec);
        snap_t s;
        m[13] = {8'h00, ec};
        for (int i = 0; i < 14; i++) s[i*16 +: 16] = m[i];
        exp_upd.push_back(s);
    endtask

    task automatic exp_ids(input int n);
        logic [1:0] ord [4];
        ord = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < n; i++) exp_req.push_back(ord[i]);
    endtask

    task automatic full_round(input logic [7:0] ec);
        exp_ids(4);
        apply(1); apply(2); apply(3); apply(0);
        push_snap(ec);
    endtask

    task automatic wait_upd(input int target);
        int k;
        k = 0;
        while (upd_cnt < target && k < 1500) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (upd_cnt < target) begin
            errors++;
            $display("FAIL update_wait: got %0d rounds expected %0d", upd_cnt, target);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hb;
        int k;
        for (int i = 0; i < 14; i++) m[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", {15'd0, REQ}, 16'd0);
        chk("rst_hm_tr", {15'd0, HM_TR}, 16'd0);
        chk("rst_update", {15'd0, UPDATE}, 16'd0);
        chk("rst_err_cnt", {8'd0, ERR_CNT}, 16'd0);
        chk("rst_temp", {8'd0, Temperature}, 16'd0);
        chk("rst_mag_z", MZ, 16'd0);
        rst_n = 1'b1;
        en = 1'b1;

        // Round 1: nominal words
        w1 = '{16'h0011, 16'h0022};
        for (int i = 0; i < 6; i++) w2[i] = 16'(i + 1);
        for (int i = 0; i < 3; i++) w3[i] = 16'(i + 7);
        w0 = 16'h1A3C;
        full_round(8'd0);
        wait_upd(1);

        // Round 2: slot 2 fails with ERR
        cfg(16'h0100, 16'h5566);
        err_slot = 2;
        exp_ids(4);
        apply(1); apply(3); apply(0);
        push_snap(8'd1);
        wait_upd(2);

        // Round 3: DRDY never asserts
        err_slot = 7;
        drdy_hold = 1'b1;
        cfg(16'h0200, 16'h7788);
        exp_ids(3);
        apply(1); apply(2); apply(3);
        push_snap(8'd2);
        wait_upd(3);

        // Round 4: slow engine, round spans several ticks
        drdy_hold = 1'b0;
        ack_dly = 40;
        done_dly = 40;
        cfg(16'h0300, 16'h99AA);
        full_round(8'd2);
        wait_upd(4);

        // Round 5 must start right away; drop EN during slot 2
        hb = hm_cnt;
        ack_dly = 0;
        done_dly = 0;
        cfg(16'h0400, 16'hBBCC);
        full_round(8'd2);
        repeat (4) @(negedge clk);
        chk("pending_round", 16'(hm_cnt), 16'(hb + 1));
        k = 0;
        while (!(REQ && REQ_ID == 2'd2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("slot2_seen", 16'(k < 200), 16'd1);
        en = 1'b0;
        wait_upd(5);
        hb = hm_cnt;
        repeat (250) @(negedge clk);
        chk("en_low_idle", 16'(hm_cnt), 16'(hb));

        // Round 6: EN back high, pending tick starts a round
        cfg(16'h0500, 16'hDDEE);
        full_round(8'd2);
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("en_high_round", 16'(hm_cnt), 16'(hb + 1));
        wait_upd(6);

        // Round 7: reset during slot 1 collection
        done_dly = 30;
        exp_req.push_back(2'd1);
        hb = hm_cnt;
        k = 0;
        while (hm_cnt == hb && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("round7_start", 16'(hm_cnt), 16'(hb + 1));
        repeat (8) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {15'd0, REQ}, 16'd0);
        chk("mid_rst_hm_tr", {15'd0, HM_TR}, 16'd0);
        chk("mid_rst_update", {15'd0, UPDATE}, 16'd0);
        chk("mid_rst_temp", {8'd0, Temperature}, 16'd0);
        chk("mid_rst_hum", {8'd0, HUMITY}, 16'd0);
        chk("mid_rst_light0", L0, 16'd0);
        chk("mid_rst_acc_x", AX, 16'd0);
        chk("mid_rst_mag_x", MX, 16'd0);
        chk("mid_rst_err_cnt", {8'd0, ERR_CNT}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_dly = 0;
        for (int i = 0; i < 14; i++) m[i] = '0;
        cfg(16'h0600, 16'h1234);
        full_round(8'd0);
        wait_upd(7);

        repeat (5) @(negedge clk);
        chk("req_queue_empty", 16'(exp_req.size()), 16'd0);
        chk("upd_queue_empty", 16'(exp_upd.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
